// File: rtl/mux_scanner.sv
// Round-robin sequencer for a D_COUNT-way mux. It steps addr through the channels,
// waits SETTLE cycles on each one, and emits each captured word as a valid/ready beat tagged with its channel.
module mux_scanner #(
    parameter int D_SIZE  = 2,
    parameter int D_COUNT = 3,
    parameter int A_SIZE  = 2,
    parameter int SETTLE  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    output logic [A_SIZE-1:0] addr,
    input  logic [D_SIZE-1:0] mux_data,
    output logic [D_SIZE-1:0] out_data,
    output logic [A_SIZE-1:0] out_chan,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              frame_done
);

    generate
        if (D_COUNT < 1 || D_COUNT > (1 << A_SIZE) || SETTLE < 0) begin : g_bad_params
            $error("mux_scanner: need 1 <= D_COUNT <= 2**A_SIZE and SETTLE >= 0");
        end
    endgenerate

    localparam int                CNT_W     = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(SETTLE);
    localparam logic [A_SIZE-1:0] LAST_CHAN = A_SIZE'(D_COUNT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_HOLD
    } state_t;

    state_t              state_q, state_d;
    logic [A_SIZE-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [D_SIZE-1:0]   out_data_q, out_data_d;
    logic [A_SIZE-1:0]   out_chan_q, out_chan_d;
    logic                out_valid_q, out_valid_d;
    logic                frame_done_q, frame_done_d;
    logic                accept;

    assign accept = out_valid_q && out_ready;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            cnt_q        <= '0;
            out_data_q   <= '0;
            out_chan_q   <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            out_data_q   <= out_data_d;
            out_chan_q   <= out_chan_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    // NOTE: default every always_comb output first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (enable)       state_d = ST_WAIT;
            ST_WAIT: if (cnt_q == '0)  state_d = ST_HOLD;
            ST_HOLD: if (accept)       state_d = enable ? ST_WAIT : ST_IDLE;
            default:                   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        out_data_d   = out_data_q;
        out_chan_d   = out_chan_q;
        out_valid_d  = out_valid_q;
        frame_done_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                addr_d = '0;
                if (enable) cnt_d = CNT_LOAD;
            end
            ST_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    out_data_d  = mux_data;
                    out_chan_d  = addr_q;
                    out_valid_d = 1'b1;
                end
            end
            ST_HOLD: begin
                if (accept) begin
                    out_valid_d  = 1'b0;
                    frame_done_d = (addr_q == LAST_CHAN);
                    // Leaving the sweep (enable low) returns addr to 0 so the next sweep starts at channel 0.
                    if (addr_q == LAST_CHAN || !enable) addr_d = '0;
                    else                                addr_d = addr_q + 1'b1;
                    if (enable) cnt_d = CNT_LOAD;
                end
            end
            default: addr_d = '0;
        endcase
    end

    assign addr       = addr_q;
    assign out_data   = out_data_q;
    assign out_chan   = out_chan_q;
    assign out_valid  = out_valid_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_mux_scanner.sv
// Self-checking bench for mux_scanner: a cycle table for the main sweep and enable drop,
// plus directed stall, reset-in-HOLD and SETTLE=0/4 period sequences.
module tb_mux_scanner;

    localparam logic [5:0] INDATA = 6'b00_01_10;

    logic       clk = 1'b0;
    logic       rst, enable, out_ready;
    logic [1:0] addr, mux_data, out_data, out_chan;
    logic       out_valid, frame_done;

    logic       rst_b, en_b;
    logic [1:0] addr_0, mux_0, data_0, chan_0;
    logic       valid_0, fd_0;
    logic [1:0] addr_4, mux_4, data_4, chan_4;
    logic       valid_4, fd_4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [1:0] mux_of(input logic [1:0] a);
        return (a < 2'd3) ? INDATA[a*2 +: 2] : 2'b00;
    endfunction

    // Expected channel words, written out independently of the mux model.
    function automatic logic [1:0] exp_word(input int chan);
        case (chan)
            0:       return 2'b10;
            1:       return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    assign mux_data = mux_of(addr);
    assign mux_0    = mux_of(addr_0);
    assign mux_4    = mux_of(addr_4);

    mux_scanner #(.D_SIZE(2), .D_COUNT(3), .A_SIZE(2), .SETTLE(1)) u_dut (
        .clk(clk), .rst(rst), .enable(enable), .addr(addr), .mux_data(mux_data),
        .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid),
        .out_ready(out_ready), .frame_done(frame_done)
    );

    mux_scanner #(.D_SIZE(2), .D_COUNT(3), .A_SIZE(2), .SETTLE(0)) u_s0 (
        .clk(clk), .rst(rst_b), .enable(en_b), .addr(addr_0), .mux_data(mux_0),
        .out_data(data_0), .out_chan(chan_0), .out_valid(valid_0),
        .out_ready(1'b1), .frame_done(fd_0)
    );

    mux_scanner #(.D_SIZE(2), .D_COUNT(3), .A_SIZE(2), .SETTLE(4)) u_s4 (
        .clk(clk), .rst(rst_b), .enable(en_b), .addr(addr_4), .mux_data(mux_4),
        .out_data(data_4), .out_chan(chan_4), .out_valid(valid_4),
        .out_ready(1'b1), .frame_done(fd_4)
    );

    typedef struct {
        logic       en;
        logic       rdy;
        logic [1:0] addr;
        logic       valid;
        logic [1:0] chan;
        logic [1:0] data;
        logic       fd;
    } vec_t;

    vec_t vecs [20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int got, guard, fds, k, n0, n4, last0, last4;

        vecs[0]  = '{1'b1, 1'b1, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 2'd0, 1'b1, 2'd0, 2'b10, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 2'd1, 1'b0, 2'd0, 2'd0, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 2'd1, 1'b0, 2'd0, 2'd0, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 2'd1, 1'b1, 2'd1, 2'b01, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 2'd2, 1'b0, 2'd0, 2'd0, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 2'd2, 1'b0, 2'd0, 2'd0, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 2'd2, 1'b1, 2'd2, 2'b00, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 2'd0, 1'b0, 2'd0, 2'd0, 1'b1};
        vecs[10] = '{1'b1, 1'b1, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 2'd0, 1'b1, 2'd0, 2'b10, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 2'd1, 1'b0, 2'd0, 2'd0, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 2'd1, 1'b0, 2'd0, 2'd0, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 2'd1, 1'b1, 2'd1, 2'b01, 1'b0};
        vecs[15] = '{1'b0, 1'b1, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0};
        vecs[16] = '{1'b0, 1'b1, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0};
        vecs[17] = '{1'b1, 1'b1, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0};
        vecs[18] = '{1'b1, 1'b1, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0};
        vecs[19] = '{1'b1, 1'b1, 2'd0, 1'b1, 2'd0, 2'b10, 1'b0};

        rst = 1'b1; enable = 1'b0; out_ready = 1'b0;
        rst_b = 1'b1; en_b = 1'b0;

        // Reset, then idle with enable low.
        repeat (3) step();
        check("rst addr", 32'(addr), 32'd0);
        check("rst valid", 32'(out_valid), 32'd0);
        check("rst frame_done", 32'(frame_done), 32'd0);
        check("rst out_data", 32'(out_data), 32'd0);
        check("rst out_chan", 32'(out_chan), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            check($sformatf("idle%0d addr", i), 32'(addr), 32'd0);
            check($sformatf("idle%0d valid", i), 32'(out_valid), 32'd0);
            check($sformatf("idle%0d frame_done", i), 32'(frame_done), 32'd0);
        end

        // Cycle table: full sweep, wrap, enable drop in WAIT, re-enable from channel 0.
        for (int i = 0; i < 20; i++) begin
            enable    = vecs[i].en;
            out_ready = vecs[i].rdy;
            step();
            check($sformatf("vec%0d addr", i), 32'(addr), 32'(vecs[i].addr));
            check($sformatf("vec%0d valid", i), 32'(out_valid), 32'(vecs[i].valid));
            check($sformatf("vec%0d frame_done", i), 32'(frame_done), 32'(vecs[i].fd));
            if (vecs[i].valid) begin
                check($sformatf("vec%0d chan", i), 32'(out_chan), 32'(vecs[i].chan));
                check($sformatf("vec%0d data", i), 32'(out_data), 32'(vecs[i].data));
            end
        end

        // Stall 10 cycles in HOLD on channel 0.
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check($sformatf("stall%0d valid", i), 32'(out_valid), 32'd1);
            check($sformatf("stall%0d chan", i), 32'(out_chan), 32'd0);
            check($sformatf("stall%0d data", i), 32'(out_data), 32'(2'b10));
            check($sformatf("stall%0d addr", i), 32'(addr), 32'd0);
        end

        // Release: six words in order, each exactly once, two frame pulses.
        out_ready = 1'b1;
        got = 0; guard = 0; fds = 0;
        while (got < 6 && guard < 100) begin
            if (out_valid) begin
                check($sformatf("drain%0d chan", got), 32'(out_chan), 32'(got % 3));
                check($sformatf("drain%0d data", got), 32'(out_data), 32'(exp_word(got % 3)));
                got++;
            end
            step();
            if (frame_done) fds++;
            guard++;
        end
        check("drain word count", 32'(got), 32'd6);
        check("drain frame pulses", 32'(fds), 32'd2);

        // Reach HOLD on channel 2 with ready low, then reset during a would-be accept.
        guard = 0;
        while (!(out_valid && out_chan == 2'd2) && guard < 30) begin
            out_ready = 1'b1;
            step();
            guard++;
        end
        out_ready = 1'b0;
        check("hold2 reached", 32'(out_valid && out_chan == 2'd2), 32'd1);
        check("hold2 addr", 32'(addr), 32'd2);
        rst = 1'b1; out_ready = 1'b1;
        step();
        check("rst_hold valid", 32'(out_valid), 32'd0);
        check("rst_hold addr", 32'(addr), 32'd0);
        check("rst_hold frame_done", 32'(frame_done), 32'd0);
        rst = 1'b0; enable = 1'b0;
        step();
        check("post_rst valid", 32'(out_valid), 32'd0);
        check("post_rst frame_done", 32'(frame_done), 32'd0);

        // SETTLE=0 and SETTLE=4 builds: latency, period and data per channel.
        rst_b = 1'b0;
        step();
        en_b = 1'b1;
        n0 = 0; n4 = 0; last0 = 0; last4 = 0;
        for (k = 1; k <= 40; k++) begin
            step();
            if (valid_0) begin
                check($sformatf("s0 word%0d gap", n0), 32'(k - last0), 32'd2);
                check($sformatf("s0 word%0d chan", n0), 32'(chan_0), 32'(n0 % 3));
                check($sformatf("s0 word%0d data", n0), 32'(data_0), 32'(exp_word(n0 % 3)));
                last0 = k; n0++;
            end
            if (valid_4) begin
                check($sformatf("s4 word%0d gap", n4), 32'(k - last4), 32'd6);
                check($sformatf("s4 word%0d chan", n4), 32'(chan_4), 32'(n4 % 3));
                check($sformatf("s4 word%0d data", n4), 32'(data_4), 32'(exp_word(n4 % 3)));
                last4 = k; n4++;
            end
        end
        check("s0 word count", 32'(n0), 32'd20);
        check("s4 word count", 32'(n4), 32'd6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
